en2pulse_stretch: RTL and testbench
===================================

// Module: en2pulse_stretch
// PURPOSE
//   Inverse of the edge-to-enable converter: turns single-cycle enable strobes into
//   clean output pulses of fixed width, each followed by a minimum low gap.
//   Strobes arriving while a pulse is in flight are queued in a saturating counter
//   and replayed back-to-back. Drives LEDs, external strobes and slow peripherals
//   from clk-domain enables.
// PARAMETERS
//   HIGH_CYC  4  output high time per pulse in clk cycles, >=1
//   GAP_CYC   2  forced low time between queued pulses in clk cycles, >=1
//   QDEPTH    3  max pending strobes held while busy, >=1
// PORTS
//   clk      in   1                    system clock, rising edge
//   rst_n    in   1                    asynchronous reset, active-low
//   en       in   1                    request strobe; each high cycle = one request
//   out      out  1                    stretched pulse output, registered
//   busy     out  1                    1 whenever FSM is not IDLE
//   pending  out  $clog2(QDEPTH+1)     queued requests not yet started
//   ovf      out  1                    sticky drop flag (only with EN2PULSE_OVF_EN)
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, out=0, busy=0, pending=0, ovf=0 immediately;
//   any pulse in progress is aborted. Released state is IDLE with empty queue.
// - All outputs registered; no combinational path from en to any output.
// - FSM states IDLE, HIGH, GAP; down-counter sized for max(HIGH_CYC,GAP_CYC).
//   IDLE: en=1 -> HIGH next cycle (out=1, counter=HIGH_CYC). Latency en->out = 1 clk.
//   HIGH: out=1 for exactly HIGH_CYC cycles. On the last HIGH cycle:
//     next pending>0 -> GAP (counter=GAP_CYC); else -> IDLE.
//     "next pending" includes an en accepted in that same cycle.
//   GAP: out=0 for exactly GAP_CYC cycles, then -> HIGH and pending decrements by 1.
// - en while busy (HIGH or GAP): pending+1, saturating at QDEPTH.
//   en in the same cycle as the GAP->HIGH decrement: net change 0, never dropped.
//   en with pending==QDEPTH and no decrement that cycle: request dropped.
// - en in IDLE never touches pending (starts pulse directly).
// - en held high N cycles = N requests (level, not edge; source must pre-strobe).
// - busy = (state != IDLE); pending updates on the edge after the causing event.
// - No wrap-around: pending never exceeds QDEPTH nor underflows below 0.
// CONFIGURATION
//   EN2PULSE_OVF_EN defined: port ovf present; set to 1 on the edge after any dropped
//     request, stays 1 until rst_n asserted.
//   EN2PULSE_OVF_EN undefined: no ovf port, no drop-tracking logic; drops are silent.
//   All other behaviour identical in both builds.
// TESTING (defaults HIGH_CYC=4, GAP_CYC=2, QDEPTH=3; cycle n = n-th clk after en)
// - Single en at cycle 0 -> out=1 cycles 1-4, busy=1 cycles 1-4, out=busy=0 at cycle 5.
// - en at cycles 0 and 2 -> out high 1-4, low 5-6, high 7-10; pending=1 cycles 3-6,
//   0 from cycle 7.
// - en in cycle 4 (last HIGH) only after initial en at 0 -> GAP 5-6, HIGH 7-10, IDLE 11.
// - en held high cycles 0-5 -> pending saturates at 3, 2 requests dropped, exactly
//   4 pulses total; ovf=1 from cycle 5 with EN2PULSE_OVF_EN, stays 1 until reset.
// - rst_n low mid-HIGH (cycle 2, between edges) -> out, busy, pending drop to 0
//   immediately; after release, single en gives normal 4-cycle pulse.
// - HIGH_CYC=1, GAP_CYC=1, en at cycles 0,1,2 -> out pattern 1,0,1,0,1 over
//   cycles 1-5, then IDLE; pending never exceeds 2.

Source files
------------

// File: rtl/en2pulse_stretch.sv
// ----------------------------------------------------------------------------
// en2pulse_stretch
//
// Turns single-cycle enable strobes into clean output pulses of HIGH_CYC
// cycles, separated by at least GAP_CYC low cycles. Strobes that arrive while
// a pulse (or the gap after it) is in progress are counted in a saturating
// queue and replayed back-to-back.
//
// Parameters
//   HIGH_CYC  output high time per pulse, clk cycles (>=1)
//   GAP_CYC   forced low time between queued pulses, clk cycles (>=1)
//   QDEPTH    max pending strobes held while busy (>=1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous reset, active-low
//   en       in   request strobe, one request per high cycle
//   out      out  stretched pulse, registered
//   busy     out  1 whenever the FSM is not IDLE, registered
//   pending  out  queued requests not yet started, registered
//   ovf      out  sticky drop flag (only when EN2PULSE_OVF_EN is defined)
//
// Build option
//   EN2PULSE_OVF_EN  adds the ovf port and the drop-tracking logic. Without
//                    it, requests arriving with a full queue vanish silently.
// ----------------------------------------------------------------------------
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | nothing in flight, queue empty; en starts a pulse directly
//   HIGH  | out=1, counter runs down from HIGH_CYC
//   GAP   | out=0 between queued pulses, counter runs down from GAP_CYC
// ----------------------------------------------------------------------------
module en2pulse_stretch #(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int QDEPTH   = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic                        out,
    output logic                        busy,
    output logic [$clog2(QDEPTH+1)-1:0] pending
`ifdef EN2PULSE_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int CNT_MAX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [PW-1:0]   pend_nx;
    logic            tc;
    logic            full;
    logic            inc;
    logic            dec;

    // ------------------------------------------------------------------
    // State, counter and queue registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pending <= pend_nx;
            // Outputs are registered copies of the next state so that no
            // combinational path exists from en to any port.
            out     <= (state_nx == ST_HIGH);
            busy    <= (state_nx != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and queue logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pending;

        // Terminal count: the current cycle is the last one of the phase.
        tc   = (cnt == CW'(1));
        full = (pending == PW'(QDEPTH));

        // A queued request is consumed on the GAP->HIGH transition. The
        // pending guard only protects against underflow; GAP is never
        // entered with an empty queue.
        dec  = (state == ST_GAP) && tc && (pending != '0);
        // en in IDLE starts the pulse itself and never touches the queue.
        inc  = (state != ST_IDLE) && en;

        // A request coinciding with a consume nets to zero, even when full.
        if (inc && dec) begin
            pend_nx = pending;
        end else if (dec) begin
            pend_nx = pending - PW'(1);
        end else if (inc && !full) begin
            pend_nx = pending + PW'(1);
        end

        unique case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nx = ST_HIGH;
                    cnt_nx   = CW'(HIGH_CYC);
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    // pend_nx already includes an en accepted this cycle.
                    if (pend_nx != '0) begin
                        state_nx = ST_GAP;
                        cnt_nx   = CW'(GAP_CYC);
                    end else begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (tc) begin
                    state_nx = ST_HIGH;
                    cnt_nx   = CW'(HIGH_CYC);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef EN2PULSE_OVF_EN
    // ------------------------------------------------------------------
    // Sticky drop flag: a request is lost only when the queue is full
    // and nothing is consumed in the same cycle.
    // ------------------------------------------------------------------
    logic drop;

    always_comb begin
        drop = inc && full && !dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_en2pulse_stretch.sv
module tb_en2pulse_stretch;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int Q  = 3;
    localparam int PW = $clog2(Q + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
`ifdef EN2PULSE_OVF_EN
    logic          ovf;
`endif

    always #5 clk = ~clk;

    en2pulse_stretch #(
        .HIGH_CYC (H),
        .GAP_CYC  (G),
        .QDEPTH   (Q)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .out     (out),
        .busy    (busy),
        .pending (pending)
`ifdef EN2PULSE_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;

    // Reference model: absolute start cycle of every scheduled pulse.
    int starts[$];
    bit ovf_exp = 1'b0;

    logic [63:0] tr_out;
    logic [63:0] tr_busy;
    int          tr_pend [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic bit m_out(input int c);
        foreach (starts[i])
            if (starts[i] <= c && c <= starts[i] + H - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(input int c);
        if (m_out(c)) return 1'b1;
        foreach (starts[i])
            if (c >= starts[i] + H && c < starts[i] + H + G)
                foreach (starts[j])
                    if (starts[j] == starts[i] + H + G) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pend(input int c);
        int n = 0;
        foreach (starts[i]) if (starts[i] > c) n++;
        return n;
    endfunction

    // Apply a request seen in cycle c; its effect is visible from c+1.
    task automatic m_step(input int c, input bit e);
        bit starting;
        while (starts.size() > 0 && starts[0] + H + G + 2 < c) void'(starts.pop_front());
        if (!e) return;
        if (starts.size() == 0 || c > starts[$] + H - 1) begin
            starts.push_back(c + 1);
        end else begin
            starting = 1'b0;
            foreach (starts[i]) if (starts[i] == c + 1) starting = 1'b1;
            if (m_pend(c) < Q || starting) starts.push_back(starts[$] + H + G);
            else ovf_exp = 1'b1;
        end
    endtask

    // One clock cycle: check outputs mid-cycle, drive en, advance.
    task automatic cycle(input bit e);
        int idx;
        @(negedge clk);
        idx = cyc - t0;
        if (idx >= 0 && idx < 64) begin
            tr_out[idx]  = out;
            tr_busy[idx] = busy;
            tr_pend[idx] = int'(pending);
        end
        chk("out",     out,     m_out(cyc));
        chk("busy",    busy,    m_busy(cyc));
        chk("pending", pending, m_pend(cyc));
`ifdef EN2PULSE_OVF_EN
        chk("ovf",     ovf,     ovf_exp);
`endif
        en = e;
        m_step(cyc, e);
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic start_trace();
        t0      = cyc;
        tr_out  = '0;
        tr_busy = '0;
        for (int i = 0; i < 64; i++) tr_pend[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("rst_out",     out,     0);
        chk("rst_busy",    busy,    0);
        chk("rst_pending", pending, 0);
`ifdef EN2PULSE_OVF_EN
        chk("rst_ovf",     ovf,     0);
`endif
        starts.delete();
        ovf_exp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    function automatic int count_pulses(input logic [63:0] tr);
        int n = 0;
        for (int i = 1; i < 64; i++) if (tr[i] && !tr[i-1]) n++;
        return n;
    endfunction

    initial begin
        logic [11:0] tr12;
        int          dens;

        // Reset values while held in reset
        #3;
        chk("init_out",     out,     0);
        chk("init_busy",    busy,    0);
        chk("init_pending", pending, 0);
`ifdef EN2PULSE_OVF_EN
        chk("init_ovf",     ovf,     0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        idle_cycles(3);

        // Single strobe
        start_trace();
        cycle(1'b1);
        idle_cycles(10);
        tr12 = tr_out[11:0];
        chk("single_out", tr12, 12'b000000011110);
        tr12 = tr_busy[11:0];
        chk("single_busy", tr12, 12'b000000011110);

        // Strobes at 0 and 2
        start_trace();
        cycle(1'b1); cycle(1'b0); cycle(1'b1);
        idle_cycles(12);
        tr12 = tr_out[11:0];
        chk("two_out", tr12, 12'b011110011110);
        chk("two_pend_c3", tr_pend[3], 1);
        chk("two_pend_c6", tr_pend[6], 1);
        chk("two_pend_c7", tr_pend[7], 0);

        // Strobe on the last HIGH cycle
        start_trace();
        cycle(1'b1); cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
        idle_cycles(10);
        tr12 = tr_out[11:0];
        chk("last_out", tr12, 12'b011110011110);
        tr12 = tr_busy[11:0];
        chk("last_busy", tr12, 12'b011111111110);

        // en held for six cycles: saturation and drops
        start_trace();
        for (int i = 0; i < 6; i++) cycle(1'b1);
        idle_cycles(30);
        chk("sat_pend_c4", tr_pend[4], 3);
        chk("sat_pulses", count_pulses(tr_out), 4);
`ifdef EN2PULSE_OVF_EN
        chk("sat_ovf_sticky", ovf, 1);
`endif

        // Reset in the middle of HIGH
        cycle(1'b1);
        cycle(1'b0);
        @(negedge clk);
        chk("prerst_out", out, 1);
        @(posedge clk);
        cyc++;
        do_reset();
        idle_cycles(2);
        start_trace();
        cycle(1'b1);
        idle_cycles(8);
        tr12 = tr_out[11:0];
        chk("postrst_out", tr12, 12'b000000011110);

        // Randomized traffic at several densities, with a reset midway
        for (int blk = 0; blk < 4; blk++) begin
            dens = (blk == 0) ? 10 : (blk == 1) ? 35 : (blk == 2) ? 65 : 90;
            for (int i = 0; i < 400; i++) cycle($urandom_range(0, 99) < dens);
            if (blk == 1) do_reset();
        end
        idle_cycles(40);
        chk("end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
